ijtag_access_ctrl: RTL and testbench

IJTAG_ACCESS_CTRL -- requirements
Module: ijtag_access_ctrl

---
 rtl/ijtag_acc_pkg.sv | 23 ++
 rtl/ijtag_access_ctrl_if.sv | 39 +++
 rtl/ijtag_acc_shifter.sv | 62 ++++++
 rtl/ijtag_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_ijtag_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ijtag_acc_pkg.sv
// Shared types for the IJTAG access controller: FSM states, default segment
// length and the 6-bit length type.
package ijtag_acc_pkg;

   localparam int unsigned MAX_LEN_DEF = 32;
   localparam int unsigned LEN_W       = 6;

   typedef logic [LEN_W-1:0] len_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CAPTURE = 3'd1,
      SHIFT   = 3'd2,
      UPDATE  = 3'd3,
      RESP    = 3'd4
   } state_t;

   // A segment length is usable only when it is non-zero and fits the shifter.
   function automatic logic len_legal(input len_t len, input int unsigned max_len);
      return (len != 6'd0) && (32'(len) <= max_len);
   endfunction

endpackage

// File: rtl/ijtag_access_ctrl_if.sv
// Request/response handshake bundle of the IJTAG access controller.
// The req_abort wire exists only when IJTAG_ACCESS_CTRL_ABORT_EN is defined.
interface ijtag_access_ctrl_if import ijtag_acc_pkg::*; #(
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
) ();

   logic               req_valid;
   logic               req_ready;
   len_t               req_len;
   logic [MAX_LEN-1:0] req_wdata;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [MAX_LEN-1:0] rsp_rdata;
   logic               rsp_err;
`ifdef IJTAG_ACCESS_CTRL_ABORT_EN
   logic               req_abort;

   modport master (
      output req_valid, req_len, req_wdata, rsp_ready, req_abort,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_len, req_wdata, rsp_ready, req_abort,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`else
   modport master (
      output req_valid, req_len, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_len, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`endif

endinterface

// File: rtl/ijtag_acc_shifter.sv
// Scan data path: write-data shift register, indexed capture of scan-out
// into rdata, and the down-counting shift counter.
module ijtag_acc_shifter import ijtag_acc_pkg::*; #(
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
   input  logic               ijtag_tck,
   input  logic               ijtag_reset,
   input  logic               load,
   input  logic               shift_en,
   input  logic               shift_nxt,
   input  len_t               len,
   input  logic [MAX_LEN-1:0] wdata,
   input  logic               so,
   output logic               si,
   output logic               cnt_zero,
   output logic [MAX_LEN-1:0] rdata
);

   logic [MAX_LEN-1:0] wsh_r;
   logic [MAX_LEN-1:0] wsh_nxt_s;
   logic [MAX_LEN-1:0] rdata_r;
   len_t               cnt_r;
   len_t               len_r;
   len_t               bit_idx_s;
   logic               si_r;

   assign wsh_nxt_s = shift_en ? (wsh_r >> 1) : wsh_r;
   assign bit_idx_s = len_r - cnt_r - 6'd1;
   assign cnt_zero  = (cnt_r == 6'd0);
   assign si        = si_r;
   assign rdata     = rdata_r;

   // Load on accept, then shift one bit per SHIFT cycle; si is pre-computed for the coming cycle.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         wsh_r   <= '0;
         rdata_r <= '0;
         cnt_r   <= 6'd0;
         len_r   <= 6'd0;
         si_r    <= 1'b0;
      end else begin
         si_r <= shift_nxt & wsh_nxt_s[0];
         if (load) begin
            wsh_r   <= wdata;
            rdata_r <= '0;
            len_r   <= len;
            cnt_r   <= (len == 6'd0) ? 6'd0 : (len - 6'd1);
         end else if (shift_en) begin
            wsh_r <= wsh_nxt_s;
            cnt_r <= cnt_zero ? cnt_r : (cnt_r - 6'd1);
            for (int j = 0; j < int'(MAX_LEN); j++) begin
               if (bit_idx_s == len_t'(j)) begin
                  rdata_r[j] <= so;
               end
            end
         end else begin
            wsh_r <= wsh_r;
         end
      end
   end

endmodule

// File: rtl/ijtag_access_ctrl.sv
// IJTAG segment access controller: capture, shift len bits, update, respond.
// Optional abort input enabled by defining IJTAG_ACCESS_CTRL_ABORT_EN.
module ijtag_access_ctrl import ijtag_acc_pkg::*; #(
   parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
   input  logic                ijtag_tck,
   input  logic                ijtag_reset,
   ijtag_access_ctrl_if.slave  bus,
   output logic                ijtag_sel,
   output logic                ijtag_ce,
   output logic                ijtag_se,
   output logic                ijtag_ue,
   output logic                ijtag_si,
   input  logic                ijtag_so
);

   state_t state_r;
   state_t state_nxt_s;
   logic   accept_s;
   logic   legal_s;
   logic   abort_s;
   logic   shift_en_s;
   logic   cnt_zero_s;
   logic   err_nxt_s;
   logic   sel_nxt_s, ce_nxt_s, se_nxt_s, ue_nxt_s, ready_nxt_s, valid_nxt_s;
   logic   sel_r, ce_r, se_r, ue_r, req_ready_r, rsp_valid_r, rsp_err_r;

`ifdef IJTAG_ACCESS_CTRL_ABORT_EN
   assign abort_s = bus.req_abort & ((state_r == CAPTURE) | (state_r == SHIFT));
`else
   assign abort_s = 1'b0;
`endif

   assign accept_s   = (state_r == IDLE) & bus.req_valid;
   assign legal_s    = len_legal(bus.req_len, MAX_LEN);
   // An aborting cycle does not sample scan-out, so rdata keeps only completed bits.
   assign shift_en_s = (state_r == SHIFT) & ~abort_s;

   ijtag_acc_shifter #(.MAX_LEN(MAX_LEN)) u_shifter (
      .ijtag_tck   (ijtag_tck),
      .ijtag_reset (ijtag_reset),
      .load        (accept_s),
      .shift_en    (shift_en_s),
      .shift_nxt   (state_nxt_s == SHIFT),
      .len         (bus.req_len),
      .wdata       (bus.req_wdata),
      .so          (ijtag_so),
      .si          (ijtag_si),
      .cnt_zero    (cnt_zero_s),
      .rdata       (bus.rsp_rdata)
   );

   // Next-state and error-flag decode.
   always_comb begin
      state_nxt_s = state_r;
      err_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.req_valid) begin
               if (legal_s) begin
                  state_nxt_s = CAPTURE;
               end else begin
                  state_nxt_s = RESP;
                  err_nxt_s   = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CAPTURE: begin
            if (abort_s) begin
               state_nxt_s = RESP;
               err_nxt_s   = 1'b1;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         SHIFT: begin
            if (abort_s) begin
               state_nxt_s = RESP;
               err_nxt_s   = 1'b1;
            end else if (cnt_zero_s) begin
               state_nxt_s = UPDATE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         UPDATE: state_nxt_s = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
               err_nxt_s   = rsp_err_r;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode from the next state so every drive pin comes straight from a flop.
   always_comb begin
      sel_nxt_s   = 1'b0;
      ce_nxt_s    = 1'b0;
      se_nxt_s    = 1'b0;
      ue_nxt_s    = 1'b0;
      ready_nxt_s = 1'b0;
      valid_nxt_s = 1'b0;
      case (state_nxt_s)
         IDLE:    ready_nxt_s = 1'b1;
         CAPTURE: begin sel_nxt_s = 1'b1; ce_nxt_s = 1'b1; end
         SHIFT:   begin sel_nxt_s = 1'b1; se_nxt_s = 1'b1; end
         UPDATE:  begin sel_nxt_s = 1'b1; ue_nxt_s = 1'b1; end
         RESP:    valid_nxt_s = 1'b1;
         default: ready_nxt_s = 1'b0;
      endcase
   end

   // State and output registers; reset drops the network and abandons any access.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         state_r     <= IDLE;
         sel_r       <= 1'b0;
         ce_r        <= 1'b0;
         se_r        <= 1'b0;
         ue_r        <= 1'b0;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         sel_r       <= sel_nxt_s;
         ce_r        <= ce_nxt_s;
         se_r        <= se_nxt_s;
         ue_r        <= ue_nxt_s;
         req_ready_r <= ready_nxt_s;
         rsp_valid_r <= valid_nxt_s;
         rsp_err_r   <= err_nxt_s;
      end
   end

   assign ijtag_sel     = sel_r;
   assign ijtag_ce      = ce_r;
   assign ijtag_se      = se_r;
   assign ijtag_ue      = ue_r;
   assign bus.req_ready = req_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_ijtag_access_ctrl.sv
// Scoreboard bench for ijtag_access_ctrl with a loopback scan-segment model;
// the abort scenario runs only when IJTAG_ACCESS_CTRL_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_ijtag_access_ctrl;
   import ijtag_acc_pkg::*;

   localparam int unsigned MAX_LEN = 32;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] si_bits;
      int          n_sel;
      int          n_cap;
      int          n_shift;
      int          n_ue;
      int          ue_off;
      int          rsp_off;
      logic [31:0] upd;
   } exp_t;

   logic ijtag_tck = 1'b0;
   logic ijtag_reset;
   logic ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
   logic ijtag_so = 1'b0;

   int          err_cnt = 0;
   int          chk_cnt = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          sel_cnt, cap_cnt, shift_cnt, ue_cnt, ue_off, rsp_off;
   logic [31:0] si_obs;
   logic        bad_drive;
   logic        rsp_seen;
   logic [31:0] exp_upd = 32'h0000_00F3;
   exp_t        sb_q[$];

   // Network model: loopback segment whose capture value is the last update value.
   logic [31:0] m_seg = 32'h0;
   logic [31:0] m_upd = 32'h0000_00F3;
   int          m_len = 1;

   ijtag_access_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

   ijtag_access_ctrl #(.MAX_LEN(MAX_LEN)) dut (
      .ijtag_tck   (ijtag_tck),
      .ijtag_reset (ijtag_reset),
      .bus         (bus),
      .ijtag_sel   (ijtag_sel),
      .ijtag_ce    (ijtag_ce),
      .ijtag_se    (ijtag_se),
      .ijtag_ue    (ijtag_ue),
      .ijtag_si    (ijtag_si),
      .ijtag_so    (ijtag_so)
   );

   always #5 ijtag_tck = ~ijtag_tck;

   always @(posedge ijtag_tck) cyc <= cyc + 1;

   function automatic logic [31:0] len_mask(input int n);
      if (n >= 32)     return 32'hFFFF_FFFF;
      else if (n <= 0) return 32'h0;
      else             return (32'h1 << n) - 32'h1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge ijtag_tck) begin
      if (ijtag_sel && ijtag_ce)
         m_seg <= m_upd & len_mask(m_len);
      else if (ijtag_sel && ijtag_se)
         m_seg <= ((m_seg & len_mask(m_len)) >> 1) | ({31'h0, ijtag_si} << (m_len - 1));
      else if (ijtag_sel && ijtag_ue)
         m_upd <= m_seg;
   end

   always @(negedge ijtag_tck) ijtag_so <= m_seg[0];

   // Per-cycle observation of the network drive and response pop.
   always @(negedge ijtag_tck) begin : mon
      exp_t e;
      if (ijtag_reset) begin
         if (ijtag_sel) sel_cnt++;
         if (ijtag_sel && ijtag_ce) cap_cnt++;
         if (ijtag_sel && ijtag_se) begin
            if (shift_cnt < 32) si_obs[shift_cnt] = ijtag_si;
            shift_cnt++;
         end
         if (ijtag_ue) begin
            ue_cnt++;
            ue_off = cyc - acc_cyc;
         end
         if (!ijtag_sel && (ijtag_ce || ijtag_se || ijtag_ue)) bad_drive = 1'b1;
         if (!ijtag_se && ijtag_si) bad_drive = 1'b1;
         if (bus.rsp_valid && !rsp_seen) begin
            rsp_seen = 1'b1;
            rsp_off  = cyc - acc_cyc;
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check_eq("rdata",     bus.rsp_rdata, e.rdata);
               check_eq("err",       {31'h0, bus.rsp_err}, {31'h0, e.err});
               check_eq("si_bits",   si_obs, e.si_bits);
               check_eq("sel_cycles", sel_cnt, e.n_sel);
               check_eq("captures",  cap_cnt, e.n_cap);
               check_eq("shifts",    shift_cnt, e.n_shift);
               check_eq("ue_pulses", ue_cnt, e.n_ue);
               check_eq("rsp_latency", rsp_off, e.rsp_off);
               check_eq("net_update", m_upd, e.upd);
               check_eq("drive_rules", {31'h0, bad_drive}, 32'd0);
               if (e.n_ue > 0) check_eq("ue_latency", ue_off, e.ue_off);
            end
         end
      end
   end

   task automatic clear_obs();
      acc_cyc   = cyc;
      sel_cnt   = 0;
      cap_cnt   = 0;
      shift_cnt = 0;
      ue_cnt    = 0;
      ue_off    = -1;
      rsp_off   = -1;
      si_obs    = 32'h0;
      bad_drive = 1'b0;
      rsp_seen  = 1'b0;
   endtask

   task automatic do_req(input int len, input logic [31:0] wdata, input int hold, input int abort_at);
      exp_t e;
      logic legal;
      int   n;
      int   guard;
      legal     = (len >= 1) && (len <= 32);
      n         = legal ? len : 0;
      e.rdata   = legal ? (exp_upd & len_mask(len)) : 32'h0;
      e.err     = !legal;
      e.si_bits = wdata & len_mask(n);
      e.n_sel   = legal ? n + 2 : 0;
      e.n_cap   = legal ? 1 : 0;
      e.n_shift = n;
      e.n_ue    = legal ? 1 : 0;
      e.ue_off  = n + 1;
      e.rsp_off = legal ? n + 2 : 0;
      if (abort_at >= 0) begin
         e.rdata   = e.rdata & len_mask(abort_at);
         e.err     = 1'b1;
         e.si_bits = wdata & len_mask(abort_at + 1);
         e.n_sel   = abort_at + 2;
         e.n_shift = abort_at + 1;
         e.n_ue    = 0;
         e.rsp_off = abort_at + 2;
      end else if (legal) begin
         exp_upd = wdata & len_mask(len);
      end
      e.upd = exp_upd;
      sb_q.push_back(e);
      m_len = len;

      @(posedge ijtag_tck); #1;
      bus.req_valid = 1'b1;
      bus.req_len   = len_t'(len);
      bus.req_wdata = wdata;
      guard = 0;
      @(negedge ijtag_tck);
      while (!bus.req_ready && guard < 50) begin
         @(negedge ijtag_tck);
         guard++;
      end
      if (guard >= 50) check_eq("req_timeout", 32'd0, 32'd1);
      @(posedge ijtag_tck); #1;
      clear_obs();
      bus.req_valid = 1'b0;
`ifdef IJTAG_ACCESS_CTRL_ABORT_EN
      if (abort_at >= 0) begin
         while (cyc - acc_cyc < abort_at + 1) begin
            @(posedge ijtag_tck); #1;
         end
         bus.req_abort = 1'b1;
         @(posedge ijtag_tck); #1;
         bus.req_abort = 1'b0;
      end
`endif
      guard = 0;
      while (!bus.rsp_valid && guard < 100) begin
         @(negedge ijtag_tck);
         guard++;
      end
      if (guard >= 100) check_eq("rsp_timeout", 32'd0, 32'd1);
      for (int k = 0; k < hold; k++) begin
         @(negedge ijtag_tck);
         check_eq("hold_valid", {31'h0, bus.rsp_valid}, 32'd1);
         check_eq("hold_rdata", bus.rsp_rdata, e.rdata);
         check_eq("hold_ready", {31'h0, bus.req_ready}, 32'd0);
      end
      @(posedge ijtag_tck); #1;
      bus.rsp_ready = 1'b1;
      @(posedge ijtag_tck); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic reset_mid_shift();
      m_len = 9;
      @(posedge ijtag_tck); #1;
      bus.req_valid = 1'b1;
      bus.req_len   = 6'd9;
      bus.req_wdata = 32'h0000_01A5;
      @(posedge ijtag_tck); #1;
      clear_obs();
      bus.req_valid = 1'b0;
      while (cyc - acc_cyc < 5) begin
         @(posedge ijtag_tck); #1;
      end
      #2;
      ijtag_reset = 1'b0;
      #1;
      check_eq("arst_drive", {27'h0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 32'd0);
      check_eq("arst_ready", {31'h0, bus.req_ready}, 32'd1);
      check_eq("arst_valid", {30'h0, bus.rsp_valid, bus.rsp_err}, 32'd0);
      check_eq("arst_rdata", bus.rsp_rdata, 32'h0);
      check_eq("arst_shifts_seen", shift_cnt, 32'd4);
      @(negedge ijtag_tck);
      ijtag_reset = 1'b1;
      repeat (4) @(negedge ijtag_tck);
      check_eq("arst_no_ue", ue_cnt, 32'd0);
      check_eq("arst_no_rsp", {31'h0, rsp_seen}, 32'd0);
      check_eq("arst_idle", {30'h0, bus.req_ready, ijtag_sel}, 32'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ijtag_reset   = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_len   = 6'd0;
      bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b0;
`ifdef IJTAG_ACCESS_CTRL_ABORT_EN
      bus.req_abort = 1'b0;
`endif
      clear_obs();
      repeat (3) @(negedge ijtag_tck);
      check_eq("rst_ready", {31'h0, bus.req_ready}, 32'd1);
      check_eq("rst_rsp",   {30'h0, bus.rsp_valid, bus.rsp_err}, 32'd0);
      check_eq("rst_rdata", bus.rsp_rdata, 32'h0);
      check_eq("rst_drive", {27'h0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 32'd0);
      ijtag_reset = 1'b1;

      do_req(9, 32'h0000_01A5, 0, -1);
      do_req(0, 32'h1234_5678, 0, -1);
      do_req(33, 32'hFFFF_FFFF, 1, -1);
      do_req(32, 32'hDEAD_BEEF, 5, -1);
      do_req(32, 32'h5A5A_C3C3, 0, -1);
      do_req(1, 32'h0000_0001, 0, -1);
      for (int r = 0; r < 3; r++) begin
         do_req(int'($urandom_range(2, 32)), $urandom, int'($urandom_range(0, 2)), -1);
      end
      reset_mid_shift();
      do_req(5, 32'h0000_0016, 0, -1);
`ifdef IJTAG_ACCESS_CTRL_ABORT_EN
      do_req(9, 32'h0000_00AB, 0, 3);
      do_req(7, 32'h0000_0055, 0, -1);
`endif
      repeat (2) @(negedge ijtag_tck);
      check_eq("sb_leftover", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
